// File: rtl/mem_wb_pkg.sv
// MEM/WB shared types: default widths, writeback entry layout and the writeback data select.
package mem_wb_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;

  typedef struct packed {
    logic                   regwrite;
    logic [RADDR_W_DEF-1:0] waddr;
    logic [DATA_W_DEF-1:0]  wdata;
  } wb_entry_t;

  function automatic logic [DATA_W_DEF-1:0] wb_select(
    input logic                  memtoreg,
    input logic [DATA_W_DEF-1:0] dm,
    input logic [DATA_W_DEF-1:0] alu
  );
    return memtoreg ? dm : alu;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer: 1-cycle latency, full throughput; in_ready is
// registered (!skid), so one extra beat is absorbed when out_ready drops.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic         skid_vld;
  logic [W-1:0] main_dat;
  logic [W-1:0] skid_dat;
  logic         accept;
  logic         consume;

  // skid_vld implies main_vld, so an accept never meets a full skid
  assign accept  = in_valid && !skid_vld;
  assign consume = main_vld && out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (consume) begin
      if (skid_vld) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_dat <= in_data;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_vld <= 1'b1;
        main_dat <= in_data;
      end else begin
        skid_vld <= 1'b1;
        skid_dat <= in_data;
      end
    end
  end

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB stage: selects writeback data at capture, gates x0 writes, 1-cycle latency via a
// registered-ready skid buffer. MEM_WB_FWD_EN adds the EX source-register hit compare.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_regwrite,
  input  logic               in_memtoreg,
  input  logic [DATA_W-1:0]  in_dm_data,
  input  logic [DATA_W-1:0]  in_alu_data,
  input  logic [RADDR_W-1:0] in_waddr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_regwrite,
  output logic [RADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0]  out_wdata
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [RADDR_W-1:0] fwd_rs,
  input  logic [RADDR_W-1:0] fwd_rt,
  output logic               fwd_rs_hit,
  output logic               fwd_rt_hit
`endif
);

  localparam int PW = 1 + RADDR_W + DATA_W;

  logic          cap_regwrite;
  logic [PW-1:0] in_pay;
  logic [PW-1:0] out_pay;

  assign cap_regwrite = in_regwrite && (in_waddr != '0);

  generate
    if (DATA_W == DATA_W_DEF && RADDR_W == RADDR_W_DEF) begin : g_def
      wb_entry_t cap;
      assign cap.regwrite = cap_regwrite;
      assign cap.waddr    = in_waddr;
      assign cap.wdata    = wb_select(in_memtoreg, in_dm_data, in_alu_data);
      assign in_pay       = cap;
    end else begin : g_gen
      assign in_pay = {cap_regwrite, in_waddr, (in_memtoreg ? in_dm_data : in_alu_data)};
    end
  endgenerate

  pipe_skid_buf #(.W(PW)) u_skid (
    .clock    (clock),
    .resetn   (resetn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pay),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pay)
  );

  assign out_regwrite = out_valid && out_pay[PW-1];
  assign out_waddr    = out_pay[DATA_W +: RADDR_W];
  assign out_wdata    = out_pay[DATA_W-1:0];

`ifdef MEM_WB_FWD_EN
  // out_regwrite already includes out_valid; kept explicit to match the hit definition
  assign fwd_rs_hit = out_valid && out_regwrite && (out_waddr == fwd_rs);
  assign fwd_rt_hit = out_valid && out_regwrite && (out_waddr == fwd_rt);
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: queue model of a 2-deep FIFO checked every negedge plus literal spot checks.
module tb_mem_wb_pipe;

  logic        clock = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [31:0] in_dm_data;
  logic [31:0] in_alu_data;
  logic [4:0]  in_waddr;
  logic        out_valid;
  logic        out_ready;
  logic        out_regwrite;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
`ifdef MEM_WB_FWD_EN
  logic [4:0]  fwd_rs;
  logic [4:0]  fwd_rt;
  logic        fwd_rs_hit;
  logic        fwd_rt_hit;
`endif

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  always #10 clock = ~clock;

  mem_wb_pipe #(.DATA_W(32), .RADDR_W(5)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_regwrite (in_regwrite),
    .in_memtoreg (in_memtoreg),
    .in_dm_data  (in_dm_data),
    .in_alu_data (in_alu_data),
    .in_waddr    (in_waddr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_regwrite(out_regwrite),
    .out_waddr   (out_waddr),
    .out_wdata   (out_wdata)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage behaves as an ordered queue of at most two entries.
  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;
  exp_t q[$];

  always @(negedge resetn) q.delete();

  always @(posedge clock) begin : model
    int   n;
    exp_t e;
    if (resetn) begin
      if (flush) begin
        q.delete();
      end else begin
        n = q.size();
        if (out_ready && n > 0) void'(q.pop_front());
        if (in_valid && n < 2) begin
          e.rw = in_regwrite && (in_waddr != 5'd0);
          e.wa = in_waddr;
          e.wd = in_memtoreg ? in_dm_data : in_alu_data;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      if (q.size() > 0) begin
        chk("out_regwrite", {63'd0, out_regwrite}, {63'd0, q[0].rw});
        chk("out_waddr", {59'd0, out_waddr}, {59'd0, q[0].wa});
        chk("out_wdata", {32'd0, out_wdata}, {32'd0, q[0].wd});
`ifdef MEM_WB_FWD_EN
        chk("fwd_rs_hit", {63'd0, fwd_rs_hit}, {63'd0, q[0].rw && q[0].wa == fwd_rs});
        chk("fwd_rt_hit", {63'd0, fwd_rt_hit}, {63'd0, q[0].rw && q[0].wa == fwd_rt});
`endif
      end else begin
        chk("out_regwrite_idle", {63'd0, out_regwrite}, 64'd0);
`ifdef MEM_WB_FWD_EN
        chk("fwd_rs_hit_idle", {63'd0, fwd_rs_hit}, 64'd0);
        chk("fwd_rt_hit_idle", {63'd0, fwd_rt_hit}, 64'd0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_k(input int k);
    in_valid    = 1'b1;
    in_regwrite = 1'b1;
    in_memtoreg = k[0];
    in_dm_data  = 32'hAAAA0000 + k;
    in_alu_data = 32'h00005555 + k;
    in_waddr    = k[4:0];
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_regwrite"}, {63'd0, out_regwrite}, 64'd0);
    chk({tag, "_out_waddr"}, {59'd0, out_waddr}, 64'd0);
    chk({tag, "_out_wdata"}, {32'd0, out_wdata}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
`ifdef MEM_WB_FWD_EN
    chk({tag, "_fwd_rs_hit"}, {63'd0, fwd_rs_hit}, 64'd0);
    chk({tag, "_fwd_rt_hit"}, {63'd0, fwd_rt_hit}, 64'd0);
`endif
  endtask

  logic [31:0] stream_exp [1:4];

  initial begin
    stream_exp[1] = 32'hAAAA0001;
    stream_exp[2] = 32'h00005557;
    stream_exp[3] = 32'hAAAA0003;
    stream_exp[4] = 32'h00005559;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
    in_dm_data = '0; in_alu_data = '0; in_waddr = '0; out_ready = 1'b1;
`ifdef MEM_WB_FWD_EN
    fwd_rs = 5'd0; fwd_rt = 5'd0;
`endif
    #5;
    check_reset_vals("reset");
    #3 resetn = 1'b1;
    chk_on = 1'b1;
    tick();

    // stream: 1 entry per cycle, 1-cycle latency, dm/alu alternating
    for (int i = 1; i <= 4; i++) begin
      send_k(i);
      tick();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_waddr", {59'd0, out_waddr}, i);
      chk("stream_wdata", {32'd0, out_wdata}, {32'd0, stream_exp[i]});
    end
    in_valid = 1'b0;
    tick();

    // backpressure: out_ready low for 3 cycles
    send_k(5); tick();
    send_k(6); out_ready = 1'b0; tick();
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_head", {32'd0, out_wdata}, 64'hAAAA0005);
    send_k(7); tick();
    tick();
    out_ready = 1'b1; tick();
    chk("bp_skid_to_main", {32'd0, out_wdata}, 64'h0000555B);
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_e7", {32'd0, out_wdata}, 64'hAAAA0007);
    in_valid = 1'b0; tick();

    // x0 write suppression
    in_valid = 1'b1; in_regwrite = 1'b1; in_memtoreg = 1'b0;
    in_dm_data = 32'h0; in_alu_data = 32'hDEADBEEF; in_waddr = 5'd0;
    tick();
    chk("x0_valid", {63'd0, out_valid}, 64'd1);
    chk("x0_regwrite", {63'd0, out_regwrite}, 64'd0);
    chk("x0_wdata", {32'd0, out_wdata}, 64'hDEADBEEF);
    in_valid = 1'b0; tick();

`ifdef MEM_WB_FWD_EN
    fwd_rs = 5'd7; fwd_rt = 5'd8;
    send_k(7); out_ready = 1'b0; tick();
    chk("fwd_rs_hit_r7", {63'd0, fwd_rs_hit}, 64'd1);
    chk("fwd_rt_hit_r8", {63'd0, fwd_rt_hit}, 64'd0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    send_k(7); in_regwrite = 1'b0; out_ready = 1'b0; tick();
    chk("fwd_rs_nowrite", {63'd0, fwd_rs_hit}, 64'd0);
    chk("fwd_rt_nowrite", {63'd0, fwd_rt_hit}, 64'd0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
`endif

    // flush with skid full and an input presented
    out_ready = 1'b0;
    send_k(10); tick();
    send_k(11); tick();
    chk("fl_skid_full", {63'd0, in_ready}, 64'd0);
    send_k(12); flush = 1'b1; tick();
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("fl_nothing_left", {63'd0, out_valid}, 64'd0);
    send_k(13); tick();
    chk("fl_next_entry", {59'd0, out_waddr}, 64'd13);
    in_valid = 1'b0; tick();

    // async reset between edges with both slots full
    out_ready = 1'b0;
    send_k(14); tick();
    send_k(15); tick();
    send_k(16);
    #2 resetn = 1'b0;
    #1 check_reset_vals("areset");
    #2 resetn = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("areset_first_accept_valid", {63'd0, out_valid}, 64'd1);
    chk("areset_first_accept_waddr", {59'd0, out_waddr}, 64'd16);
    in_valid = 1'b0;
    tick();
    tick();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
